dmem_responder: RTL and testbench

Data-memory responder that answers load/store requests from the RV32I core (or a bench acting as the core) over a valid/ready request channel and a valid/ready response channel. It adds a configurable number of wait states, performs byte/half/word access with sign or zero extension, and flags misaligned or out-of-range accesses. It is the memory-side counterpart of the core's load/store path and is used to model latency before the core moves to a handshaked memory port.

---
 rtl/dmem_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with wait states and sized loads/stores.
// Define DMEM_STATS_EN to add saturating read/write/error response counters.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_rd_cnt,
  output logic [CNT_WIDTH-1:0] stat_wr_cnt,
  output logic [CNT_WIDTH-1:0] stat_err_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // With zero wait states the access happens on the accepting edge, so it must use
  // the live request; otherwise it uses the captured copy.
  logic          acc_live;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic          acc_uns;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic          do_access;
  logic          do_write;

  assign acc_live  = (state_q == ST_IDLE);
  assign acc_we    = acc_live ? req_we       : we_q;
  assign acc_addr  = acc_live ? req_addr     : addr_q;
  assign acc_wdata = acc_live ? req_wdata    : wdata_q;
  assign acc_size  = acc_live ? req_size     : size_q;
  assign acc_uns   = acc_live ? req_unsigned : uns_q;
  assign acc_idx   = acc_addr[AW+1:2];

  assign acc_err = (acc_size == 2'b11)
                || ((acc_size == 2'b01) && acc_addr[0])
                || ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00))
                || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));

  assign do_access = ((state_q == ST_IDLE) && req_valid && (WAIT_CYCLES == 0))
                  || ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign do_write  = do_access && acc_we && !acc_err && !reset;

  logic [31:0] rd_word;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH] = '{default: 8'h00};

      always_ff @(posedge clk) begin
        if (do_write && wr_be[gi]) begin
          lane_mem[acc_idx] <= wr_data[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[acc_idx];
    end
  endgenerate

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_data = acc_wdata;
    wr_be   = 4'b0000;
    case (acc_size)
      2'b00: begin
        wr_data = {4{acc_wdata[7:0]}};
        wr_be   = 4'b0001 << acc_addr[1:0];
      end
      2'b01: begin
        wr_data = {2{acc_wdata[15:0]}};
        wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    byte_sel  = rd_word[acc_addr[1:0]*8 +: 8];
    half_sel  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0;
    case (acc_size)
      2'b00: load_data = acc_uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01: load_data = acc_uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b10: load_data = rd_word;
      default: load_data = 32'h0;
    endcase
    if (acc_err || acc_we) begin
      load_data = 32'h0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          size_d      = req_size;
          uns_d       = req_unsigned;
          req_ready_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data;
            rsp_err_d   = acc_err;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          rsp_err_d   = acc_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Returning to IDLE here (not accepting) costs one bubble per request.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_STATS_EN
  logic [CNT_WIDTH-1:0] stat_rd_q, stat_rd_d;
  logic [CNT_WIDTH-1:0] stat_wr_q, stat_wr_d;
  logic [CNT_WIDTH-1:0] stat_err_q, stat_err_d;
  logic                 rsp_fire;

  assign rsp_fire = rsp_valid_q && rsp_ready;

  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    if (rsp_fire) begin
      if (rsp_err_q) begin
        if (stat_err_q != {CNT_WIDTH{1'b1}}) stat_err_d = stat_err_q + 1'b1;
      end else if (we_q) begin
        if (stat_wr_q != {CNT_WIDTH{1'b1}}) stat_wr_d = stat_wr_q + 1'b1;
      end else begin
        if (stat_rd_q != {CNT_WIDTH{1'b1}}) stat_rd_d = stat_rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_rd_cnt  = stat_rd_q;
  assign stat_wr_cnt  = stat_wr_q;
  assign stat_err_cnt = stat_err_q;
`else
  // CNT_WIDTH only sizes the statistics counters, which this build omits.
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance driven from a vector table plus
// hand sequences, and a 0-wait-state instance (CNT_WIDTH=2) for latency and saturation.
module tb_dmem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid_v = 2'b00;
  logic [1:0]  req_ready_v;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [1:0]  rsp_valid_v;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata_0, rsp_rdata_1;
  logic [1:0]  rsp_err_v;
`ifdef DMEM_STATS_EN
  logic [15:0] rd0, wr0, er0;
  logic [1:0]  rd1, wr1, er1;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W0), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_v[0])
`ifdef DMEM_STATS_EN
    , .stat_rd_cnt(rd0), .stat_wr_cnt(wr0), .stat_err_cnt(er0)
`endif
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W1), .CNT_WIDTH(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_v[1])
`ifdef DMEM_STATS_EN
    , .stat_rd_cnt(rd1), .stat_wr_cnt(wr1), .stat_err_cnt(er1)
`endif
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
    v.uns = uns; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? rsp_rdata_0 : rsp_rdata_1;
  endfunction

  task automatic drive_req(input vec_t v);
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
  endtask

  task automatic scramble();
    req_we = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom_range(0, 1));
  endtask

  // Waits (bounded) for rsp_valid on the chosen instance; returns cycles since accept.
  task automatic wait_rsp(input int sel, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid_v[sel] && lat < 40);
  endtask

  task automatic do_txn(input int sel, input vec_t v);
    int   lat;
    exp_t e;
    @(negedge clk);
    drive_req(v);
    rsp_ready = 1'b1;
    lat = 0;
    while (!req_ready_v[sel] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, "_ready"}, 32'(req_ready_v[sel]), 32'd1);
    req_valid_v[sel] = 1'b1;
    @(posedge clk);
    sb_q.push_back('{v.exp_rdata, v.exp_err});
    #1;
    req_valid_v = 2'b00;
    scramble();
    wait_rsp(sel, lat);
    check({v.name, "_latency"}, 32'(lat), 32'((sel == 0) ? W0 + 1 : W1 + 1));
    e = sb_q.pop_front();
    check({v.name, "_rdata"}, rdata_of(sel), e.rdata);
    check({v.name, "_err"}, 32'(rsp_err_v[sel]), 32'(e.err));
    $display("txn %-12s dut%0d addr=%h we=%0d rdata=%h err=%0d lat=%0d",
             v.name, sel, v.addr, v.we, rdata_of(sel), rsp_err_v[sel], lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [18];
    vec_t hv;
    exp_t e;
    int   lat;

    tbl[0]  = mk("sw_0c",      1'b1, 32'h0C,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0);
    tbl[1]  = mk("lw_0c",      1'b0, 32'h0C,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    tbl[2]  = mk("lb_0f",      1'b0, 32'h0F,  32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0);
    tbl[3]  = mk("lbu_0f",     1'b0, 32'h0F,  32'h0,        2'b00, 1'b1, 32'h000000DE, 1'b0);
    tbl[4]  = mk("lh_0c",      1'b0, 32'h0C,  32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0);
    tbl[5]  = mk("sb_0d",      1'b1, 32'h0D,  32'hAABB1155, 2'b00, 1'b0, 32'h0,        1'b0);
    tbl[6]  = mk("lw_0c_b",    1'b0, 32'h0C,  32'h0,        2'b10, 1'b0, 32'hDEAD55EF, 1'b0);
    tbl[7]  = mk("lw_0e_mis",  1'b0, 32'h0E,  32'h0,        2'b10, 1'b0, 32'h0,        1'b1);
    tbl[8]  = mk("lh_01_mis",  1'b0, 32'h01,  32'h0,        2'b01, 1'b0, 32'h0,        1'b1);
    tbl[9]  = mk("size11",     1'b0, 32'h0C,  32'h0,        2'b11, 1'b0, 32'h0,        1'b1);
    tbl[10] = mk("lw_100_oor", 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1);
    tbl[11] = mk("sw_0e_mis",  1'b1, 32'h0E,  32'h12345678, 2'b10, 1'b0, 32'h0,        1'b1);
    tbl[12] = mk("lwu_0c",     1'b0, 32'h0C,  32'h0,        2'b10, 1'b1, 32'hDEAD55EF, 1'b0);
    tbl[13] = mk("lhu_0e",     1'b0, 32'h0E,  32'h0,        2'b01, 1'b1, 32'h0000DEAD, 1'b0);
    tbl[14] = mk("sh_12",      1'b1, 32'h12,  32'hFFFF8001, 2'b01, 1'b0, 32'h0,        1'b0);
    tbl[15] = mk("sb_10",      1'b1, 32'h10,  32'hAABBCC7F, 2'b00, 1'b0, 32'h0,        1'b0);
    tbl[16] = mk("lw_10",      1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h8001007F, 1'b0);
    tbl[17] = mk("lh_12",      1'b0, 32'h12,  32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready_v[0]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_0, 32'h0);
    check("rst_rsp_err", 32'(rsp_err_v[0]), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) do_txn(0, tbl[i]);
    do_txn(0, mk("sw_fc", 1'b1, 32'hFC, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0));
    do_txn(0, mk("lw_fc", 1'b0, 32'hFC, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0));

    // Back-pressure: response held while rsp_ready=0, request pulse ignored
    @(negedge clk);
    drive_req(mk("bp_lw", 1'b0, 32'h0C, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0));
    rsp_ready = 1'b0;
    req_valid_v[0] = 1'b1;
    @(posedge clk);
    sb_q.push_back('{32'hDEAD55EF, 1'b0});
    #1 req_valid_v[0] = 1'b0;
    wait_rsp(0, lat);
    check("bp_latency", 32'(lat), 32'(W0 + 1));
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(rsp_valid_v[0]), 32'd1);
      check("bp_rdata_held", rsp_rdata_0, e.rdata);
      check("bp_req_ready", 32'(req_ready_v[0]), 32'd0);
      if (i == 1) begin
        drive_req(mk("bp_poke", 1'b1, 32'h0C, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0));
        req_valid_v[0] = 1'b1;
      end else if (i == 2) begin
        req_valid_v[0] = 1'b0;
      end
      @(negedge clk);
    end
    $display("txn %-12s dut0 addr=0000000c held rdata=%h err=%0d", "bp_lw", rsp_rdata_0, rsp_err_v[0]);
    // Request presented on the handshake edge must wait one extra cycle
    drive_req(mk("hs_lw", 1'b0, 32'h0C, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0));
    rsp_ready = 1'b1;
    req_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check("hs_rsp_valid_clr", 32'(rsp_valid_v[0]), 32'd0);
    check("hs_not_accepted", 32'(req_ready_v[0]), 32'd1);
    @(posedge clk);
    sb_q.push_back('{32'hDEAD55EF, 1'b0});
    #1 req_valid_v[0] = 1'b0;
    scramble();
    wait_rsp(0, lat);
    check("hs_latency", 32'(lat), 32'(W0 + 1));
    e = sb_q.pop_front();
    check("hs_rdata", rsp_rdata_0, e.rdata);
    $display("txn %-12s dut0 addr=0000000c rdata=%h err=%0d lat=%0d", "hs_lw", rsp_rdata_0, rsp_err_v[0], lat);
    @(posedge clk);
    #1;

    // Reset during WAIT drops the pending store
    @(negedge clk);
    drive_req(mk("rst_sw", 1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b0));
    req_valid_v[0] = 1'b1;
    @(posedge clk);
    #1 req_valid_v[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_req_ready", 32'(req_ready_v[0]), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
    check("abort_rsp_rdata", rsp_rdata_0, 32'h0);
    check("abort_rsp_err", 32'(rsp_err_v[0]), 32'd0);
    $display("txn %-12s dut0 addr=00000020 aborted by reset", "rst_sw");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_txn(0, mk("lw_20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0));

    // Zero-wait-state instance
    do_txn(1, mk("z_sw_04", 1'b1, 32'h04, 32'hA5A5A5A5, 2'b10, 1'b0, 32'h0, 1'b0));
    do_txn(1, mk("z_lw_04", 1'b0, 32'h04, 32'h0, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0));
    do_txn(1, mk("z_lb_07", 1'b0, 32'h07, 32'h0, 2'b00, 1'b0, 32'hFFFFFFA5, 1'b0));
    do_txn(1, mk("z_lw_02", 1'b0, 32'h02, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1));

`ifdef DMEM_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hv = mk("st_lw_0c", 1'b0, 32'h0C, 32'h0, 2'b10, 1'b0, 32'hDEAD55EF, 1'b0);
    do_txn(0, hv);
    do_txn(0, mk("st_lb_0f", 1'b0, 32'h0F, 32'h0, 2'b00, 1'b0, 32'hFFFFFFDE, 1'b0));
    do_txn(0, mk("st_sw_24", 1'b1, 32'h24, 32'h01020304, 2'b10, 1'b0, 32'h0, 1'b0));
    do_txn(0, mk("st_sb_25", 1'b1, 32'h25, 32'h000000FF, 2'b00, 1'b0, 32'h0, 1'b0));
    do_txn(0, mk("st_lw_24", 1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 32'h0102FF04, 1'b0));
    do_txn(0, mk("st_lw_0e", 1'b0, 32'h0E, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1));
    check("stat_rd", 32'(rd0), 32'd3);
    check("stat_wr", 32'(wr0), 32'd2);
    check("stat_err", 32'(er0), 32'd1);
    for (int i = 0; i < 5; i++)
      do_txn(1, mk("sat_lw_04", 1'b0, 32'h04, 32'h0, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0));
    check("stat_rd_sat", 32'(rd1), 32'd3);
    check("stat_wr_sat0", 32'(wr1), 32'd0);
`else
    hv = mk("final_lw", 1'b0, 32'h0C, 32'h0, 2'b10, 1'b0, 32'hDEAD55EF, 1'b0);
    do_txn(0, hv);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
